fll_cfg_seq: RTL and testbench
==============================

FLL_CFG_SEQ -- requirements
Module: fll_cfg_seq

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- LOCK_TIMEOUT, 1024: ref_clk cycles allowed for lock per attempt.
- LOCK_STABLE, 4: consecutive lock-high cycles required to declare locked.
- MAX_RETRY, 3: extra full sequences before failing.
- MULT_BASE, 16'h0100: multiplier for range=0.
- MULT_STEP, 16'h0040: multiplier increment per range step.
- CFG1_WORD, 32'h0000_0000: data for register 1.
- CFG2_WORD, 32'h0000_0000: data for register 2.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- ref_clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: pulse requesting a (re)configuration.
- range, in, 4: frequency range select, sampled at accepted start.
- opmode, in, 1: FLL operating mode, sampled at accepted start.
- cfgack, in, 1: FLL config-port acknowledge.
- lock, in, 1: FLL lock indicator, asynchronous to ref_clk, synchronised internally.
- cfgreq, out, 1: config-port request.
- cfgweb, out, 1: write enable, active-low.
- cfgad, out, 2: config register address.
- cfgd, out, 32: config write data.
- busy, out, 1: high whenever the state is not IDLE, LOCKED or FAIL.
- locked, out, 1: high in the LOCKED state.
- fail, out, 1: high in the FAIL state.
- lost_lock, out, 1: one-cycle pulse on LOCKED->LOCK_WAIT.

Function
REQ-003 The state set SHALL be IDLE, WRITE, ACK_LO, LOCK_WAIT, LOCKED and FAIL, with a 2-bit write index widx.
REQ-004 start SHALL be accepted only in IDLE, LOCKED or FAIL; start in any other state SHALL be ignored.
REQ-005 On accepted start, the block SHALL:
- latch range and opmode;
- clear widx and the retry count;
- enter WRITE on the next cycle, so cfgreq=1 one cycle after start.
REQ-006 Write words (cfgd value per address) SHALL be:
- widx=0: {opmode, 15'b0, MULT_BASE + range*MULT_STEP} (16-bit modulo).
- widx=1: CFG1_WORD.
- widx=2: CFG2_WORD.
REQ-007 In WRITE:
- cfgreq=1, cfgweb=0, cfgad=widx, cfgd=word(widx).
- All four outputs SHALL be held stable until cfgack is sampled 1.
- On cfgack=1 the block SHALL enter ACK_LO.
REQ-008 In ACK_LO:
- cfgreq=0 and cfgweb=1.
- The block SHALL wait for cfgack=0.
- Then, if widx<2, it SHALL increment widx and enter WRITE.
- If widx=2, it SHALL clear the timeout counter and enter LOCK_WAIT.
REQ-009 Outside WRITE: cfgreq=0, cfgweb=1, cfgad=0, cfgd=0.
REQ-010 The lock input SHALL pass through a 2-flop synchroniser; all lock decisions SHALL use the synchronised value (2-cycle latency).
REQ-011 In LOCK_WAIT, the block SHALL count synchronised-lock-high cycles, with the count reset to 0 on any low cycle.
REQ-012 When the stable count reaches LOCK_STABLE, the block SHALL enter LOCKED.
REQ-013 In LOCK_WAIT, the timeout counter SHALL increment every cycle.
REQ-014 When the timeout counter reaches LOCK_TIMEOUT without lock:
- if retry < MAX_RETRY: increment retry, clear widx, enter WRITE;
- otherwise: enter FAIL.
REQ-015 If lock-stable and timeout occur in the same cycle, lock SHALL win.
REQ-016 In LOCKED, a synchronised lock=0 SHALL:
- pulse lost_lock;
- clear the timeout counter and the retry count;
- enter LOCK_WAIT without rewriting the configuration.
REQ-017 FAIL SHALL be left only by an accepted start or by rst.
REQ-018 All counters SHALL saturate or clear as stated and SHALL never wrap.
REQ-019 Counter widths SHALL be $clog2(LOCK_TIMEOUT+1), $clog2(LOCK_STABLE+1) and $clog2(MAX_RETRY+1).

Reset
REQ-020 With rst=1 at a rising edge, the block SHALL:
- enter IDLE;
- drive cfgreq=0, cfgweb=1, cfgad=0, cfgd=0, busy=0, locked=0, fail=0, lost_lock=0;
- clear all counters, widx, the synchroniser and the latched inputs.
REQ-021 rst mid-handshake SHALL drop cfgreq on the next cycle; the block SHALL then wait for a new start.

Verification
REQ-022 Nominal:
- Stimulus: range=4'd3, opmode=1, start; each cfgack is a 2-cycle pulse; lock rises 10 cycles after the last ACK_LO.
- Required: writes to ad0 (data 32'h8000_01C0), ad1 and ad2 in order; locked=1 exactly 2+4 cycles after lock rises.
REQ-023 Stalled ack:
- Stimulus: cfgack withheld for 50 cycles during ad1.
- Required: cfgreq, cfgad and cfgd stay stable for all 50 cycles; no second request is issued.
REQ-024 Timeout/retry:
- Stimulus: lock never asserted, LOCK_TIMEOUT=16, MAX_RETRY=1.
- Required: two complete write sequences occur, then fail=1 and busy=0.
REQ-025 Lock glitch and loss:
- Stimulus: lock high 3 cycles, low 1 cycle, then high.
- Required: locked rises only after 4 consecutive high cycles.
- Stimulus: lock later dropped while LOCKED.
- Required: lost_lock is a 1-cycle pulse; the state is LOCK_WAIT; no cfgreq occurs.
REQ-026 Start ignored, reset mid-write:
- Stimulus: start while busy.
- Required: no effect.
- Stimulus: rst during WRITE.
- Required: cfgreq=0 on the next cycle; all REQ-020 values hold.

Source files
------------

// File: rtl/fll_cfg_seq.sv
// FLL configuration sequencer: writes three config words over the FLL config
// port, then waits for a stable synchronised lock, retrying on timeout.
module fll_cfg_seq #(
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned LOCK_STABLE  = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [15:0] MULT_BASE    = 16'h0100,
  parameter logic [15:0] MULT_STEP    = 16'h0040,
  parameter logic [31:0] CFG1_WORD    = 32'h0000_0000,
  parameter logic [31:0] CFG2_WORD    = 32'h0000_0000
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  range,
  input  logic        opmode,
  input  logic        cfgack,
  input  logic        lock,
  output logic        cfgreq,
  output logic        cfgweb,
  output logic [1:0]  cfgad,
  output logic [31:0] cfgd,
  output logic        busy,
  output logic        locked,
  output logic        fail,
  output logic        lost_lock
);

  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_ACK_LO, ST_LOCK_WAIT, ST_LOCKED, ST_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    widx_q, widx_d;
  logic [3:0]    range_q, range_d;
  logic          opmode_q, opmode_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] stb_q, stb_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lost_q, lost_d;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          accept;
  logic [15:0]   mult;

  assign lock_s = sync_q[1];
  assign accept = start && (state_q inside {ST_IDLE, ST_LOCKED, ST_FAIL});
  assign mult   = MULT_BASE + 16'(range_q) * MULT_STEP;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      widx_q   <= '0;
      range_q  <= '0;
      opmode_q <= 1'b0;
      tmo_q    <= '0;
      stb_q    <= '0;
      retry_q  <= '0;
      lost_q   <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      range_q  <= range_d;
      opmode_q <= opmode_d;
      tmo_q    <= tmo_d;
      stb_q    <= stb_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
      sync_q   <= {sync_q[0], lock};
    end
  end

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    range_d  = range_q;
    opmode_d = opmode_q;
    tmo_d    = tmo_q;
    stb_d    = stb_q;
    retry_d  = retry_q;
    lost_d   = 1'b0;
    if (accept) begin
      range_d  = range;
      opmode_d = opmode;
      widx_d   = '0;
      retry_d  = '0;
      tmo_d    = '0;
      stb_d    = '0;
      state_d  = ST_WRITE;
    end else begin
      case (state_q)
        ST_WRITE: begin
          if (cfgack) state_d = ST_ACK_LO;
        end
        ST_ACK_LO: begin
          if (!cfgack) begin
            if (widx_q < 2'd2) begin
              widx_d  = widx_q + 2'd1;
              state_d = ST_WRITE;
            end else begin
              tmo_d   = '0;
              stb_d   = '0;
              state_d = ST_LOCK_WAIT;
            end
          end
        end
        ST_LOCK_WAIT: begin
          if (!lock_s)                         stb_d = '0;
          else if (stb_q != SW'(LOCK_STABLE))  stb_d = stb_q + SW'(1);
          if (tmo_q != TW'(LOCK_TIMEOUT))      tmo_d = tmo_q + TW'(1);
          // Stable lock is tested first so it wins over a same-cycle timeout.
          if (stb_d == SW'(LOCK_STABLE)) begin
            state_d = ST_LOCKED;
          end else if (tmo_d == TW'(LOCK_TIMEOUT)) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              widx_d  = '0;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_LOCKED: begin
          if (!lock_s) begin
            lost_d  = 1'b1;
            tmo_d   = '0;
            retry_d = '0;
            stb_d   = '0;
            state_d = ST_LOCK_WAIT;
          end
        end
        ST_IDLE, ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cfgreq = 1'b0;
    cfgweb = 1'b1;
    cfgad  = '0;
    cfgd   = '0;
    if (state_q == ST_WRITE) begin
      cfgreq = 1'b1;
      cfgweb = 1'b0;
      cfgad  = widx_q;
      case (widx_q)
        2'd0:    cfgd = {opmode_q, 15'b0, mult};
        2'd1:    cfgd = CFG1_WORD;
        2'd2:    cfgd = CFG2_WORD;
        default: cfgd = '0;
      endcase
    end
  end

  assign busy      = state_q inside {ST_WRITE, ST_ACK_LO, ST_LOCK_WAIT};
  assign locked    = (state_q == ST_LOCKED);
  assign fail      = (state_q == ST_FAIL);
  assign lost_lock = lost_q;

endmodule

// File: tb/tb_fll_cfg_seq.sv
// Directed self-checking bench for fll_cfg_seq with a short lock timeout and
// a single retry so that both the lock path and the fail path are reachable.
module tb_fll_cfg_seq;

  localparam logic [31:0] W1 = 32'hA5A5_0001;
  localparam logic [31:0] W2 = 32'h5A5A_0002;

  logic        ref_clk = 1'b0;
  logic        rst, start, opmode, cfgack, lock;
  logic [3:0]  range;
  logic        cfgreq, cfgweb, busy, locked, fail, lost_lock;
  logic [1:0]  cfgad;
  logic [31:0] cfgd;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fll_cfg_seq #(
    .LOCK_TIMEOUT(16),
    .LOCK_STABLE (4),
    .MAX_RETRY   (1),
    .MULT_BASE   (16'h0100),
    .MULT_STEP   (16'h0040),
    .CFG1_WORD   (W1),
    .CFG2_WORD   (W2)
  ) dut (
    .ref_clk  (ref_clk),
    .rst      (rst),
    .start    (start),
    .range    (range),
    .opmode   (opmode),
    .cfgack   (cfgack),
    .lock     (lock),
    .cfgreq   (cfgreq),
    .cfgweb   (cfgweb),
    .cfgad    (cfgad),
    .cfgd     (cfgd),
    .busy     (busy),
    .locked   (locked),
    .fail     (fail),
    .lost_lock(lost_lock)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    check({tag, "_req"}, cfgreq, 1'b0);
    check({tag, "_web"}, cfgweb, 1'b1);
    check({tag, "_ad"},  cfgad, 2'd0);
    check({tag, "_d"},   cfgd, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_fail"}, fail, 1'b0);
    check({tag, "_lost"}, lost_lock, 1'b0);
  endtask

  task automatic chk_write(input string tag, input logic [1:0] ad, input logic [31:0] d);
    check({tag, "_req"}, cfgreq, 1'b1);
    check({tag, "_web"}, cfgweb, 1'b0);
    check({tag, "_ad"},  cfgad, ad);
    check({tag, "_d"},   cfgd, d);
  endtask

  // Two-cycle ack pulse; returns one edge after the DUT has seen ack low.
  task automatic ack_cycle(input string tag);
    cfgack = 1'b1;
    step();
    check({tag, "_acklo_req"}, cfgreq, 1'b0);
    check({tag, "_acklo_web"}, cfgweb, 1'b1);
    step();
    cfgack = 1'b0;
    step();
  endtask

  task automatic seq3(input string tag, input logic [31:0] w0);
    chk_write({tag, "_w0"}, 2'd0, w0);
    ack_cycle({tag, "_a0"});
    chk_write({tag, "_w1"}, 2'd1, W1);
    ack_cycle({tag, "_a1"});
    chk_write({tag, "_w2"}, 2'd2, W2);
    ack_cycle({tag, "_a2"});
    check({tag, "_lw_busy"}, busy, 1'b1);
    check({tag, "_lw_req"}, cfgreq, 1'b0);
  endtask

  task automatic pulse_start(input logic [3:0] r, input logic om);
    range  = r;
    opmode = om;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bad;
    rst = 1'b1; start = 1'b0; range = '0; opmode = 1'b0; cfgack = 1'b0; lock = 1'b0;
    repeat (3) step();
    chk_idle_outs("reset");
    rst = 1'b0;
    step();
    chk_idle_outs("idle");

    // Nominal sequence with a 50-cycle stall on the ad1 write.
    pulse_start(4'd3, 1'b1);
    check("nom_busy", busy, 1'b1);
    chk_write("nom_w0", 2'd0, 32'h8000_01C0);
    ack_cycle("nom_a0");
    chk_write("nom_w1", 2'd1, W1);
    bad = '0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cfgreq !== 1'b1 || cfgweb !== 1'b0 || cfgad !== 2'd1 || cfgd !== W1) bad++;
    end
    check("stall_stable", bad, 32'd0);
    ack_cycle("nom_a1");
    chk_write("nom_w2", 2'd2, W2);
    ack_cycle("nom_a2");
    check("nom_lw_busy", busy, 1'b1);
    check("nom_lw_req", cfgreq, 1'b0);
    repeat (9) step();
    lock = 1'b1;
    repeat (5) step();
    check("nom_locked_early", locked, 1'b0);
    step();
    check("nom_locked", locked, 1'b1);
    check("nom_locked_busy", busy, 1'b0);

    // Lock loss while LOCKED, then a glitch during re-acquisition.
    bad = '0;
    lock = 1'b0;
    step();
    check("loss_m1_locked", locked, 1'b1);
    step();
    check("loss_m2_lost", lost_lock, 1'b0);
    step();
    check("loss_pulse", lost_lock, 1'b1);
    check("loss_locked", locked, 1'b0);
    check("loss_busy", busy, 1'b1);
    step();
    check("loss_pulse_end", lost_lock, 1'b0);
    if (cfgreq !== 1'b0) bad++;
    lock = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (cfgreq !== 1'b0 || lost_lock !== 1'b0) bad++;
      lock = (k == 3) ? 1'b0 : 1'b1;
      if (k == 6 || k == 9) check($sformatf("glitch_k%0d", k), locked, 1'b0);
    end
    check("glitch_locked", locked, 1'b1);
    check("loss_no_req", bad, 32'd0);

    // Restart from LOCKED, ignored starts, then reset mid-write.
    pulse_start(4'd15, 1'b0);
    chk_write("rs_w0", 2'd0, 32'h0000_04C0);
    pulse_start(4'd0, 1'b1);
    chk_write("ign_write", 2'd0, 32'h0000_04C0);
    cfgack = 1'b1;
    step();
    range = 4'd1; opmode = 1'b1; start = 1'b1;
    step();
    start = 1'b0; cfgack = 1'b0;
    step();
    chk_write("ign_acklo", 2'd1, W1);
    rst = 1'b1;
    step();
    chk_idle_outs("rst_mid");
    rst = 1'b0;
    repeat (5) step();
    check("post_rst_req", cfgreq, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_locked", locked, 1'b0);

    // Timeout with one retry, ending in FAIL.
    lock = 1'b0;
    repeat (3) step();
    pulse_start(4'd0, 1'b0);
    seq3("to1", 32'h0000_0100);
    bad = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (cfgreq !== 1'b0 || fail !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("to1_wait", bad, 32'd0);
    step();
    seq3("to2", 32'h0000_0100);
    bad = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (cfgreq !== 1'b0 || fail !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("to2_wait", bad, 32'd0);
    step();
    check("fail_set", fail, 1'b1);
    check("fail_busy", busy, 1'b0);
    check("fail_req", cfgreq, 1'b0);
    repeat (4) step();
    check("fail_hold", fail, 1'b1);
    pulse_start(4'd1, 1'b0);
    check("fail_exit", fail, 1'b0);
    chk_write("fail_restart", 2'd0, 32'h0000_0140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
